serializer_pkt: RTL and testbench

//  Parametrised parallel-to-serial converter. Accepts a DATA_W-bit word plus a bit-count

---
 rtl/serializer_pkt.sv | 154 +++++++++++++++
 tb/tb_serializer_pkt.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serializer_pkt.sv
// Parallel-to-serial converter with a one-word hold buffer so consecutive words stream gap-free.
// Optional even-parity bit per word when SERIALIZER_PKT_PARITY_EN is defined.
module serializer_pkt #(
  parameter int DATA_W    = 16,
  parameter int MIN_LEN   = 3,
  parameter int MSB_FIRST = 1,
  parameter int MOD_W     = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              busy_o,
  output logic              err_o
);

`ifdef SERIALIZER_PKT_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_SHIFT = 1'b1;
  localparam logic [MOD_W:0] LEN_FULL = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] LEN_MIN  = (MOD_W+1)'(MIN_LEN);
  localparam logic [MOD_W:0] ONE      = (MOD_W+1)'(1);

  logic              state_q, state_n;
  logic [DATA_W-1:0] sh_q, sh_n;
  logic [MOD_W:0]    rem_q, rem_n;
  logic              par_q, par_n;
  logic              dout_q, dout_n;
  logic              last_q, last_n;
  logic              hold_vld_q, hold_vld_n;
  logic [DATA_W-1:0] hold_d_q, hold_d_n;
  logic [MOD_W:0]    hold_len_q, hold_len_n;
  logic              busy_q, err_q, err_n;

  logic [MOD_W:0]    len_in, ld_len;
  logic [DATA_W-1:0] ld_d;
  logic              accept, illegal, acc_ok, fin, load;

  function automatic logic head(input logic [DATA_W-1:0] d);
    return (MSB_FIRST != 0) ? d[DATA_W-1] : d[0];
  endfunction

  function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] d);
    return (MSB_FIRST != 0) ? (d << 1) : (d >> 1);
  endfunction

  assign len_in  = (data_mod_i == '0) ? LEN_FULL : {1'b0, data_mod_i};
  assign illegal = (len_in < LEN_MIN);
  assign accept  = data_val_i & ~hold_vld_q;
  assign acc_ok  = accept & ~illegal;
  // Shifter can take a new word when idle or while showing its final bit.
  assign fin     = (state_q == ST_IDLE) | last_q;

  always_comb begin
    state_n    = state_q;
    sh_n       = sh_q;
    rem_n      = rem_q;
    par_n      = par_q;
    dout_n     = dout_q;
    last_n     = last_q;
    hold_vld_n = hold_vld_q;
    hold_d_n   = hold_d_q;
    hold_len_n = hold_len_q;
    err_n      = accept & illegal;
    load       = 1'b0;
    ld_d       = data_i;
    ld_len     = len_in;
    if (fin) begin
      if (hold_vld_q) begin
        load       = 1'b1;
        ld_d       = hold_d_q;
        ld_len     = hold_len_q;
        hold_vld_n = 1'b0;
      end else if (acc_ok) begin
        load = 1'b1;
      end else begin
        state_n = ST_IDLE;
        dout_n  = 1'b0;
        last_n  = 1'b0;
      end
    end else begin
      if (acc_ok) begin
        hold_vld_n = 1'b1;
        hold_d_n   = data_i;
        hold_len_n = len_in;
      end
      if (rem_q != '0) begin
        dout_n = head(sh_q);
        sh_n   = adv(sh_q);
        rem_n  = rem_q - ONE;
        par_n  = par_q ^ head(sh_q);
        last_n = (rem_q == ONE) & ~PAR_EN;
      end else begin
        // Data bits exhausted but not last: only reachable with parity enabled.
        dout_n = par_q;
        last_n = 1'b1;
      end
    end
    if (load) begin
      state_n = ST_SHIFT;
      dout_n  = head(ld_d);
      sh_n    = adv(ld_d);
      rem_n   = ld_len - ONE;
      par_n   = head(ld_d);
      last_n  = (ld_len == ONE) & ~PAR_EN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      rem_q      <= '0;
      par_q      <= 1'b0;
      dout_q     <= 1'b0;
      last_q     <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_d_q   <= '0;
      hold_len_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      sh_q       <= sh_n;
      rem_q      <= rem_n;
      par_q      <= par_n;
      dout_q     <= dout_n;
      last_q     <= last_n;
      hold_vld_q <= hold_vld_n;
      hold_d_q   <= hold_d_n;
      hold_len_q <= hold_len_n;
      busy_q     <= (state_n == ST_SHIFT) | hold_vld_n;
      err_q      <= err_n;
    end
  end

  assign data_rdy_o     = ~hold_vld_q;
  assign ser_data_o     = dout_q;
  assign ser_data_val_o = (state_q == ST_SHIFT);
  assign ser_last_o     = last_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_serializer_pkt.sv
// Bench for serializer_pkt: an MSB-first and an LSB-first instance share one stimulus stream;
// a per-cycle expectation table built from word start times and bit order checks both.
module tb_serializer_pkt;
`ifdef SERIALIZER_PKT_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int MAXC = 4096;

  logic clk = 1'b0, srst = 1'b1, dval = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  dmod = '0;
  logic rdy0, sd0, sv0, sl0, bz0, er0;
  logic rdy1, sd1, sv1, sl1, bz1, er1;

  always #5 clk = ~clk;

  serializer_pkt #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1)) u_msb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_mod_i(dmod), .data_val_i(dval),
    .data_rdy_o(rdy0), .ser_data_o(sd0), .ser_data_val_o(sv0), .ser_last_o(sl0),
    .busy_o(bz0), .err_o(er0));

  serializer_pkt #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(0)) u_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_mod_i(dmod), .data_val_i(dval),
    .data_rdy_o(rdy1), .ser_data_o(sd1), .ser_data_val_o(sv1), .ser_last_o(sl1),
    .busy_o(bz1), .err_o(er1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected value per cycle (cycle k = interval after rising edge k).
  bit ev[MAXC], el[MAXC], eh[MAXC], ee[MAXC];
  bit eb0[MAXC], eb1[MAXC];
  int last_end = -1;
  int n_cmp = 0, n_bad = 0, n_err0 = 0;
  bit last_acc;

  int w0 = 0, c0 = 0, w1 = 0, c1 = 0;
  int qw0[$], qn0[$], qw1[$], qn1[$];

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int r);
    for (int k = r; k < MAXC; k++) begin
      ev[k] = 0; el[k] = 0; eh[k] = 0; ee[k] = 0; eb0[k] = 0; eb1[k] = 0;
    end
    last_end = -1;
  endtask

  // Word accepted at edge a starts right after the previous word's final bit, or at a.
  task automatic model_acc(input int a, input logic [15:0] d, input logic [3:0] m);
    int len, st, n;
    bit p0, p1;
    len = (m == 0) ? 16 : int'(m);
    if (len < 3) begin
      ee[a] = 1;
      return;
    end
    st = (last_end + 1 > a) ? last_end + 1 : a;
    for (int k = a; k < st; k++) eh[k] = 1;
    p0 = 0; p1 = 0;
    for (int i = 0; i < len; i++) begin
      ev[st+i] = 1;
      eb0[st+i] = d[15-i]; p0 ^= d[15-i];
      eb1[st+i] = d[i];    p1 ^= d[i];
    end
    if (PAR == 1) begin
      ev[st+len] = 1; eb0[st+len] = p0; eb1[st+len] = p1;
    end
    n = len + PAR;
    el[st+n-1] = 1;
    last_end = st + n - 1;
  endtask

  task automatic step(input bit v, input logic [15:0] d, input logic [3:0] m, input bit r);
    srst = r; dval = v; din = d; dmod = m;
    last_acc = 0;
    if (r) model_reset(cyc + 1);
    else if (v && !eh[cyc]) begin
      model_acc(cyc + 1, d, m);
      last_acc = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 4'h0, 0);
  endtask

  task automatic clr_q();
    qw0.delete(); qn0.delete(); qw1.delete(); qn1.delete();
  endtask

  task automatic chk_word(input int side, input int ew, input int en);
    int gw, gn;
    gw = -1; gn = -1;
    if (side == 0 && qw0.size() > 0) begin gw = qw0.pop_front(); gn = qn0.pop_front(); end
    if (side == 1 && qw1.size() > 0) begin gw = qw1.pop_front(); gn = qn1.pop_front(); end
    chk(side == 0 ? "word_msb" : "word_lsb", gw, ew);
    chk(side == 0 ? "len_msb" : "len_lsb", gn, en);
  endtask

  // Single compare process: all outputs of both instances against the table.
  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      chk("rdy_m",  rdy0, !eh[cyc]);      chk("rdy_l",  rdy1, !eh[cyc]);
      chk("val_m",  sv0, ev[cyc]);        chk("val_l",  sv1, ev[cyc]);
      chk("last_m", sl0, el[cyc]);        chk("last_l", sl1, el[cyc]);
      chk("busy_m", bz0, ev[cyc] | eh[cyc]); chk("busy_l", bz1, ev[cyc] | eh[cyc]);
      chk("err_m",  er0, ee[cyc]);        chk("err_l",  er1, ee[cyc]);
      chk("dat_m",  sd0, eb0[cyc]);       chk("dat_l",  sd1, eb1[cyc]);
      if (er0) n_err0++;
      if (sv0) begin
        w0 = (w0 << 1) | int'(sd0); c0++;
        if (sl0) begin qw0.push_back(w0); qn0.push_back(c0); w0 = 0; c0 = 0; end
      end else begin w0 = 0; c0 = 0; end
      if (sv1) begin
        w1 = (w1 << 1) | int'(sd1); c1++;
        if (sl1) begin qw1.push_back(w1); qn1.push_back(c1); w1 = 0; c1 = 0; end
      end else begin w1 = 0; c1 = 0; end
    end
  end

  initial begin
    logic [15:0] rd;
    int e0;
    @(posedge clk); #1;
    // Reset held with val high: nothing accepted
    for (int i = 0; i < 3; i++) step(1, 16'hBEEF, 4'h0, 1);
    chk("rst_rdy", rdy0, 1); chk("rst_val", sv0, 0); chk("rst_busy", bz0, 0);
    idle(2);
    clr_q();

    // Single full word
    step(1, 16'hA5C3, 4'h0, 0);
    idle(20);
    chk_word(0, PAR ? 32'h14B86 : 32'hA5C3, 16 + PAR);
    chk_word(1, PAR ? 32'h1874A : 32'hC3A5, 16 + PAR);

    // Back-to-back, third word waits for space
    clr_q();
    step(1, 16'hFFFF, 4'h4, 0);
    step(1, 16'h0000, 4'h5, 0);
    chk("hold_full", rdy0, 0);
    last_acc = 0;
    for (int i = 0; i < 20 && !last_acc; i++) step(1, 16'h1234, 4'h3, 0);
    idle(20);
    chk_word(0, PAR ? 32'h1E : 32'hF, 4 + PAR);
    chk_word(0, 0, 5 + PAR);
    chk_word(0, 0, 3 + PAR);
    chk_word(1, PAR ? 32'h1E : 32'hF, 4 + PAR);
    chk_word(1, 0, 5 + PAR);
    chk_word(1, PAR ? 32'h3 : 32'h1, 3 + PAR);

    // Illegal counts dropped with an error pulse each
    clr_q();
    e0 = n_err0;
    step(1, 16'hFFFF, 4'h1, 0);
    step(1, 16'hFFFF, 4'h2, 0);
    idle(3);
    chk("err_pulses", n_err0 - e0, 2);
    chk("no_words", qw0.size(), 0);
    step(1, 16'hE000, 4'h3, 0);
    idle(8);
    chk_word(0, PAR ? 32'hF : 32'h7, 3 + PAR);
    chk_word(1, 0, 3 + PAR);

    // Short word, both bit orders
    clr_q();
    step(1, 16'h0006, 4'h3, 0);
    idle(8);
    chk_word(1, PAR ? 32'h6 : 32'h3, 3 + PAR);
    chk_word(0, 0, 3 + PAR);

    // Reset mid-word with the hold buffer full
    clr_q();
    step(1, 16'h9C3A, 4'h0, 0);
    step(1, 16'h5A5A, 4'h0, 0);
    idle(5);
    step(0, 16'h0, 4'h0, 1);
    idle(30);
    chk("rst_mid_words", qw0.size() + qw1.size(), 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rd = 16'($urandom);
      step($urandom_range(0, 9) < 6, rd, 4'($urandom_range(0, 15)), $urandom_range(0, 199) == 0);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
